// File: rtl/ddr3_port_arbiter_if.sv
// rtl/ddr3_port_arbiter_if.sv - DDR3MI app port and two DMA master ports seen by the port arbiter
interface ddr3_port_arbiter_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
);
  localparam int MW = DATA_WIDTH / 8;

  logic                  I_cmd_ready;
  logic [2:0]            O_cmd;
  logic                  O_cmd_en;
  logic [5:0]            O_app_burst_number;
  logic [ADDR_WIDTH-1:0] O_addr;
  logic                  I_wr_data_rdy;
  logic                  O_wr_data_en;
  logic                  O_wr_data_end;
  logic [DATA_WIDTH-1:0] O_wr_data;
  logic [MW-1:0]         O_wr_data_mask;
  logic                  I_rd_data_valid;
  logic [DATA_WIDTH-1:0] I_rd_data;

  logic                  I_m0_cmd_en,        I_m1_cmd_en;
  logic [2:0]            I_m0_cmd,           I_m1_cmd;
  logic [ADDR_WIDTH-1:0] I_m0_addr,          I_m1_addr;
  logic [5:0]            I_m0_burst_number,  I_m1_burst_number;
  logic                  O_m0_cmd_ready,     O_m1_cmd_ready;
  logic                  O_m0_wr_data_rdy,   O_m1_wr_data_rdy;
  logic                  I_m0_wr_data_en,    I_m1_wr_data_en;
  logic                  I_m0_wr_data_end,   I_m1_wr_data_end;
  logic [DATA_WIDTH-1:0] I_m0_wr_data,       I_m1_wr_data;
  logic [MW-1:0]         I_m0_wr_data_mask,  I_m1_wr_data_mask;
  logic                  O_m0_rd_data_valid, O_m1_rd_data_valid;
  logic [DATA_WIDTH-1:0] O_m0_rd_data,       O_m1_rd_data;

  logic                  O_owner;
  logic                  O_busy;
  logic                  O_rd_timeout;

  modport slave (
    input  I_cmd_ready, I_wr_data_rdy, I_rd_data_valid, I_rd_data,
    input  I_m0_cmd_en, I_m0_cmd, I_m0_addr, I_m0_burst_number,
    input  I_m0_wr_data_en, I_m0_wr_data_end, I_m0_wr_data, I_m0_wr_data_mask,
    input  I_m1_cmd_en, I_m1_cmd, I_m1_addr, I_m1_burst_number,
    input  I_m1_wr_data_en, I_m1_wr_data_end, I_m1_wr_data, I_m1_wr_data_mask,
    output O_cmd, O_cmd_en, O_app_burst_number, O_addr,
    output O_wr_data_en, O_wr_data_end, O_wr_data, O_wr_data_mask,
    output O_m0_cmd_ready, O_m0_wr_data_rdy, O_m0_rd_data_valid, O_m0_rd_data,
    output O_m1_cmd_ready, O_m1_wr_data_rdy, O_m1_rd_data_valid, O_m1_rd_data,
    output O_owner, O_busy, O_rd_timeout
  );

  modport master (
    output I_cmd_ready, I_wr_data_rdy, I_rd_data_valid, I_rd_data,
    output I_m0_cmd_en, I_m0_cmd, I_m0_addr, I_m0_burst_number,
    output I_m0_wr_data_en, I_m0_wr_data_end, I_m0_wr_data, I_m0_wr_data_mask,
    output I_m1_cmd_en, I_m1_cmd, I_m1_addr, I_m1_burst_number,
    output I_m1_wr_data_en, I_m1_wr_data_end, I_m1_wr_data, I_m1_wr_data_mask,
    input  O_cmd, O_cmd_en, O_app_burst_number, O_addr,
    input  O_wr_data_en, O_wr_data_end, O_wr_data, O_wr_data_mask,
    input  O_m0_cmd_ready, O_m0_wr_data_rdy, O_m0_rd_data_valid, O_m0_rd_data,
    input  O_m1_cmd_ready, O_m1_wr_data_rdy, O_m1_rd_data_valid, O_m1_rd_data,
    input  O_owner, O_busy, O_rd_timeout
  );
endinterface

// File: rtl/ddr3_port_arbiter.sv
// rtl/ddr3_port_arbiter.sv - two-master whole-transaction arbiter in front of the DDR3MI app port
module ddr3_port_arbiter #(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 128,
  parameter bit M0_PRIORITY = 1'b1,
  parameter int RD_TIMEOUT  = 1023
) (
  input logic              I_dma_clk,
  input logic              I_rst_n,
  ddr3_port_arbiter_if.slave bus
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WDATA, RDATA} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [5:0]            burst_q, burst_d;
  logic [6:0]            beat_q, beat_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  rd_timeout_q, rd_timeout_d;

  logic winner, accept, own_wr_en, in_wdata, in_rdata;

  // Tie goes to M0 in priority mode, else to whoever was not served last.
  always_comb begin
    if (bus.I_m0_cmd_en && bus.I_m1_cmd_en) winner = M0_PRIORITY ? 1'b0 : ~last_q;
    else                                     winner = bus.I_m1_cmd_en;
  end

  assign accept    = (state_q == IDLE) && (bus.I_m0_cmd_en || bus.I_m1_cmd_en);
  assign in_wdata  = (state_q == WDATA);
  assign in_rdata  = (state_q == RDATA);
  assign own_wr_en = owner_q ? bus.I_m1_wr_data_en : bus.I_m0_wr_data_en;

  assign bus.O_m0_cmd_ready     = accept & ~winner;
  assign bus.O_m1_cmd_ready     = accept & winner;
  assign bus.O_cmd_en           = (state_q == ISSUE) & bus.I_cmd_ready;
  assign bus.O_cmd              = cmd_q;
  assign bus.O_addr             = addr_q;
  assign bus.O_app_burst_number = burst_q;

  assign bus.O_wr_data_en   = in_wdata & own_wr_en;
  assign bus.O_wr_data_end  = in_wdata & (owner_q ? bus.I_m1_wr_data_end : bus.I_m0_wr_data_end);
  assign bus.O_wr_data      = !in_wdata ? '0 : (owner_q ? bus.I_m1_wr_data : bus.I_m0_wr_data);
  assign bus.O_wr_data_mask = !in_wdata ? '0 : (owner_q ? bus.I_m1_wr_data_mask : bus.I_m0_wr_data_mask);

  assign bus.O_m0_wr_data_rdy   = in_wdata & ~owner_q & bus.I_wr_data_rdy;
  assign bus.O_m1_wr_data_rdy   = in_wdata &  owner_q & bus.I_wr_data_rdy;
  assign bus.O_m0_rd_data_valid = in_rdata & ~owner_q & bus.I_rd_data_valid;
  assign bus.O_m1_rd_data_valid = in_rdata &  owner_q & bus.I_rd_data_valid;
  assign bus.O_m0_rd_data       = bus.I_rd_data;
  assign bus.O_m1_rd_data       = bus.I_rd_data;

  assign bus.O_owner      = owner_q;
  assign bus.O_busy       = (state_q != IDLE);
  assign bus.O_rd_timeout = rd_timeout_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    to_d         = to_q;
    rd_timeout_d = rd_timeout_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d   = winner ? bus.I_m1_cmd          : bus.I_m0_cmd;
          addr_d  = winner ? bus.I_m1_addr         : bus.I_m0_addr;
          burst_d = winner ? bus.I_m1_burst_number : bus.I_m0_burst_number;
          owner_d = winner;
          last_d  = winner;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.I_cmd_ready) begin
          beat_d = {1'b0, burst_q} + 7'd1;
          to_d   = '0;
          case (cmd_q)
            3'd0:    state_d = WDATA;
            3'd1:    state_d = RDATA;
            default: state_d = IDLE;
          endcase
        end
      end
      WDATA: begin
        if (own_wr_en && bus.I_wr_data_rdy) begin
          beat_d = beat_q - 7'd1;
          if (beat_q == 7'd1) state_d = IDLE;
        end
      end
      RDATA: begin
        if (bus.I_rd_data_valid) begin
          beat_d = beat_q - 7'd1;
          to_d   = '0;
          if (beat_q == 7'd1) state_d = IDLE;
        end else if (to_q == TW'(RD_TIMEOUT - 1)) begin
          // Controller stalled mid-burst: give the port back, leave the sticky flag.
          rd_timeout_d = 1'b1;
          to_d         = '0;
          state_d      = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      cmd_q        <= '0;
      addr_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      to_q         <= '0;
      rd_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      to_q         <= to_d;
      rd_timeout_q <= rd_timeout_d;
    end
  end
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// tb/tb_ddr3_port_arbiter.sv - directed bench for a round-robin and a priority arbiter in lockstep
module tb_ddr3_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  ddr3_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifr ();
  ddr3_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifp ();

  ddr3_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .M0_PRIORITY(1'b0), .RD_TIMEOUT(15))
    dut_rr (.I_dma_clk(clk), .I_rst_n(rst_n), .bus(ifr));
  ddr3_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .M0_PRIORITY(1'b1), .RD_TIMEOUT(15))
    dut_pr (.I_dma_clk(clk), .I_rst_n(rst_n), .bus(ifp));

  assign ifp.I_cmd_ready       = ifr.I_cmd_ready;
  assign ifp.I_wr_data_rdy     = ifr.I_wr_data_rdy;
  assign ifp.I_rd_data_valid   = ifr.I_rd_data_valid;
  assign ifp.I_rd_data         = ifr.I_rd_data;
  assign ifp.I_m0_cmd_en       = ifr.I_m0_cmd_en;
  assign ifp.I_m0_cmd          = ifr.I_m0_cmd;
  assign ifp.I_m0_addr         = ifr.I_m0_addr;
  assign ifp.I_m0_burst_number = ifr.I_m0_burst_number;
  assign ifp.I_m0_wr_data_en   = ifr.I_m0_wr_data_en;
  assign ifp.I_m0_wr_data_end  = ifr.I_m0_wr_data_end;
  assign ifp.I_m0_wr_data      = ifr.I_m0_wr_data;
  assign ifp.I_m0_wr_data_mask = ifr.I_m0_wr_data_mask;
  assign ifp.I_m1_cmd_en       = ifr.I_m1_cmd_en;
  assign ifp.I_m1_cmd          = ifr.I_m1_cmd;
  assign ifp.I_m1_addr         = ifr.I_m1_addr;
  assign ifp.I_m1_burst_number = ifr.I_m1_burst_number;
  assign ifp.I_m1_wr_data_en   = ifr.I_m1_wr_data_en;
  assign ifp.I_m1_wr_data_end  = ifr.I_m1_wr_data_end;
  assign ifp.I_m1_wr_data      = ifr.I_m1_wr_data;
  assign ifp.I_m1_wr_data_mask = ifr.I_m1_wr_data_mask;

  typedef struct {
    logic m0_en, m1_en;
    logic r0_rr, r1_rr, r0_pr, r1_pr;
  } gvec_t;
  gvec_t gv [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    ifr.I_cmd_ready = 0; ifr.I_wr_data_rdy = 0; ifr.I_rd_data_valid = 0; ifr.I_rd_data = '0;
    ifr.I_m0_cmd_en = 0; ifr.I_m0_cmd = 0; ifr.I_m0_addr = '0; ifr.I_m0_burst_number = 0;
    ifr.I_m0_wr_data_en = 0; ifr.I_m0_wr_data_end = 0; ifr.I_m0_wr_data = '0; ifr.I_m0_wr_data_mask = '0;
    ifr.I_m1_cmd_en = 0; ifr.I_m1_cmd = 0; ifr.I_m1_addr = '0; ifr.I_m1_burst_number = 0;
    ifr.I_m1_wr_data_en = 0; ifr.I_m1_wr_data_end = 0; ifr.I_m1_wr_data = '0; ifr.I_m1_wr_data_mask = '0;
  endtask

  task automatic apply_gv(input int i);
    @(negedge clk);
    ifr.I_m0_cmd_en = gv[i].m0_en;
    ifr.I_m1_cmd_en = gv[i].m1_en;
    #1;
    chk($sformatf("gv%0d_rr_rdy0", i), ifr.O_m0_cmd_ready, gv[i].r0_rr);
    chk($sformatf("gv%0d_rr_rdy1", i), ifr.O_m1_cmd_ready, gv[i].r1_rr);
    chk($sformatf("gv%0d_pr_rdy0", i), ifp.O_m0_cmd_ready, gv[i].r0_pr);
    chk($sformatf("gv%0d_pr_rdy1", i), ifp.O_m1_cmd_ready, gv[i].r1_pr);
    ifr.I_m0_cmd_en = 0;
    ifr.I_m1_cmd_en = 0;
  endtask

  initial begin
    logic [31:0]   w;
    logic [DW-1:0] ed;
    logic          exp_rr;
    n_chk = 0;
    n_pass = 0;
    clear_inputs();

    // Entries 0-3: pointer at reset value; 4-7: after M0 was last served.
    gv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    gv[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    gv[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    gv[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    gv[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    gv[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    gv[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    gv[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", ifr.O_busy, 0);
    chk("rst_owner", ifr.O_owner, 0);
    chk("rst_cmd_en", ifr.O_cmd_en, 0);
    chk("rst_addr", ifr.O_addr, 0);
    chk("rst_timeout", ifr.O_rd_timeout, 0);
    chk("rst_wr_en", ifr.O_wr_data_en, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) apply_gv(i);

    // M0 write, burst 3
    @(negedge clk);
    ifr.I_cmd_ready = 1; ifr.I_wr_data_rdy = 1;
    ifr.I_m0_cmd_en = 1; ifr.I_m0_cmd = 3'd0; ifr.I_m0_addr = 28'h0123456; ifr.I_m0_burst_number = 6'd3;
    #1;
    chk("w_acc_rdy0", ifr.O_m0_cmd_ready, 1);
    chk("w_idle_cmd_en", ifr.O_cmd_en, 0);
    @(negedge clk);
    ifr.I_m0_cmd_en = 0;
    #1;
    chk("w_cmd_en", ifr.O_cmd_en, 1);
    chk("w_cmd", ifr.O_cmd, 0);
    chk("w_addr", ifr.O_addr, 28'h0123456);
    chk("w_burst", ifr.O_app_burst_number, 3);
    chk("w_busy", ifr.O_busy, 1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      w = 32'hA000_0000 + 32'(b);
      ed = {4{w}};
      ifr.I_m0_wr_data_en = 1; ifr.I_m0_wr_data = ed;
      ifr.I_m0_wr_data_mask = 16'h0F0F ^ 16'(b); ifr.I_m0_wr_data_end = (b == 3);
      ifr.I_m1_wr_data_en = 1; ifr.I_m1_wr_data = '1; ifr.I_m1_wr_data_mask = '1;
      #1;
      chk($sformatf("w_b%0d_busy", b), ifr.O_busy, 1);
      chk($sformatf("w_b%0d_cmd_en", b), ifr.O_cmd_en, 0);
      chk($sformatf("w_b%0d_en", b), ifr.O_wr_data_en, 1);
      chk($sformatf("w_b%0d_data", b), ifr.O_wr_data, ed);
      chk($sformatf("w_b%0d_mask", b), ifr.O_wr_data_mask, 16'h0F0F ^ 16'(b));
      chk($sformatf("w_b%0d_end", b), ifr.O_wr_data_end, (b == 3));
      chk($sformatf("w_b%0d_rdy0", b), ifr.O_m0_wr_data_rdy, 1);
      chk($sformatf("w_b%0d_rdy1", b), ifr.O_m1_wr_data_rdy, 0);
    end
    @(negedge clk);
    #1;
    chk("w_done_busy_rr", ifr.O_busy, 0);
    chk("w_done_busy_pr", ifp.O_busy, 0);
    chk("w_done_wr_en", ifr.O_wr_data_en, 0);
    chk("w_done_rdy0", ifr.O_m0_wr_data_rdy, 0);
    chk("w_done_addr_held", ifr.O_addr, 28'h0123456);
    clear_inputs();

    for (int i = 4; i < 8; i++) apply_gv(i);

    // Both request burst-0 reads from a fresh pointer
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      exp_rr = (t == 1);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_stray_v0", t), ifr.O_m0_rd_data_valid | ifp.O_m0_rd_data_valid, 0);
      chk($sformatf("rr%0d_stray_v1", t), ifr.O_m1_rd_data_valid | ifp.O_m1_rd_data_valid, 0);
      ifr.I_rd_data_valid = 0;
      ifr.I_cmd_ready = 1;
      ifr.I_m0_cmd_en = 1; ifr.I_m0_cmd = 3'd1; ifr.I_m0_addr = 28'h0000100; ifr.I_m0_burst_number = 0;
      ifr.I_m1_cmd_en = 1; ifr.I_m1_cmd = 3'd1; ifr.I_m1_addr = 28'h0000200; ifr.I_m1_burst_number = 0;
      #1;
      chk($sformatf("rr%0d_rr_rdy0", t), ifr.O_m0_cmd_ready, !exp_rr);
      chk($sformatf("rr%0d_rr_rdy1", t), ifr.O_m1_cmd_ready, exp_rr);
      chk($sformatf("rr%0d_pr_rdy0", t), ifp.O_m0_cmd_ready, 1);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_rr_owner", t), ifr.O_owner, exp_rr);
      chk($sformatf("rr%0d_pr_owner", t), ifp.O_owner, 0);
      chk($sformatf("rr%0d_rr_addr", t), ifr.O_addr, exp_rr ? 28'h0000200 : 28'h0000100);
      @(negedge clk);
      ifr.I_rd_data_valid = 1; ifr.I_rd_data = {4{32'h5EED_0000 + 32'(t)}};
      #1;
      chk($sformatf("rr%0d_rr_v0", t), ifr.O_m0_rd_data_valid, !exp_rr);
      chk($sformatf("rr%0d_rr_v1", t), ifr.O_m1_rd_data_valid, exp_rr);
      chk($sformatf("rr%0d_pr_v0", t), ifp.O_m0_rd_data_valid, 1);
      chk($sformatf("rr%0d_pr_v1", t), ifp.O_m1_rd_data_valid, 0);
      chk($sformatf("rr%0d_rdata", t), ifr.O_m1_rd_data, {4{32'h5EED_0000 + 32'(t)}});
    end
    @(negedge clk);
    ifr.I_rd_data_valid = 0;
    ifr.I_m0_cmd_en = 0;
    #1;
    chk("pr_m1_rdy_when_m0_drops", ifp.O_m1_cmd_ready, 1);
    chk("pr_m0_rdy_when_m0_drops", ifp.O_m0_cmd_ready, 0);
    @(negedge clk);
    ifr.I_m1_cmd_en = 0;
    #1;
    chk("pr_owner_m1", ifp.O_owner, 1);
    @(negedge clk);
    ifr.I_rd_data_valid = 1;
    #1;
    chk("pr_m1_valid", ifp.O_m1_rd_data_valid, 1);
    @(negedge clk);
    ifr.I_rd_data_valid = 0;
    #1;
    chk("pr_m1_done", ifp.O_busy, 0);
    clear_inputs();

    // Read burst 7, only 3 beats return
    @(negedge clk);
    ifr.I_cmd_ready = 1;
    ifr.I_m0_cmd_en = 1; ifr.I_m0_cmd = 3'd1; ifr.I_m0_addr = 28'h0ABCDE0; ifr.I_m0_burst_number = 6'd7;
    @(negedge clk);
    ifr.I_m0_cmd_en = 0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      ifr.I_rd_data_valid = 1;
      #1;
      chk($sformatf("to_beat%0d_v0", b), ifr.O_m0_rd_data_valid, 1);
    end
    @(negedge clk);
    ifr.I_rd_data_valid = 0;
    #1;
    chk("to_start_busy", ifr.O_busy, 1);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      #1;
      if (i < 15) begin
        chk($sformatf("to_idle%0d_busy", i), ifr.O_busy, 1);
        chk($sformatf("to_idle%0d_flag", i), ifr.O_rd_timeout, 0);
      end else begin
        chk("to_flag_rr", ifr.O_rd_timeout, 1);
        chk("to_flag_pr", ifp.O_rd_timeout, 1);
        chk("to_idle", ifr.O_busy, 0);
      end
    end
    @(negedge clk);
    ifr.I_rd_data_valid = 1;
    #1;
    chk("to_late_beat_dropped", ifr.O_m0_rd_data_valid, 0);
    @(negedge clk);
    ifr.I_rd_data_valid = 0;
    ifr.I_wr_data_rdy = 1;
    ifr.I_m1_cmd_en = 1; ifr.I_m1_cmd = 3'd0; ifr.I_m1_addr = 28'h0777000; ifr.I_m1_burst_number = 6'd1;
    @(negedge clk);
    ifr.I_m1_cmd_en = 0;
    #1;
    chk("to_w_owner", ifr.O_owner, 1);
    chk("to_w_cmd_en", ifr.O_cmd_en, 1);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      ed = {2{64'hC0DE_0000_0000_0000 + 64'(b)}};
      ifr.I_m1_wr_data_en = 1; ifr.I_m1_wr_data = ed;
      #1;
      chk($sformatf("to_w%0d_data", b), ifr.O_wr_data, ed);
      chk($sformatf("to_w%0d_rdy1", b), ifr.O_m1_wr_data_rdy, 1);
      chk($sformatf("to_w%0d_rdy0", b), ifr.O_m0_wr_data_rdy, 0);
    end
    @(negedge clk);
    ifr.I_m1_wr_data_en = 0;
    #1;
    chk("to_w_done", ifr.O_busy, 0);
    chk("to_flag_sticky", ifr.O_rd_timeout, 1);
    clear_inputs();

    // Command stalled 20 cycles; stray read beats in IDLE and ISSUE
    @(negedge clk);
    ifr.I_rd_data_valid = 1;
    ifr.I_m0_cmd_en = 1; ifr.I_m0_cmd = 3'd1; ifr.I_m0_addr = 28'h0F0F0F0; ifr.I_m0_burst_number = 0;
    #1;
    chk("st_idle_stray_v0", ifr.O_m0_rd_data_valid, 0);
    chk("st_idle_stray_v1", ifr.O_m1_rd_data_valid, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ifr.I_m0_cmd_en = 0;
      #1;
      chk($sformatf("st%0d_cmd_en", i), ifr.O_cmd_en, 0);
      chk($sformatf("st%0d_cmd", i), ifr.O_cmd, 1);
      chk($sformatf("st%0d_addr", i), ifr.O_addr, 28'h0F0F0F0);
      chk($sformatf("st%0d_v0", i), ifr.O_m0_rd_data_valid, 0);
    end
    @(negedge clk);
    ifr.I_cmd_ready = 1;
    ifr.I_rd_data_valid = 0;
    #1;
    chk("st_issue", ifr.O_cmd_en, 1);
    @(negedge clk);
    ifr.I_rd_data_valid = 1;
    #1;
    chk("st_beat", ifr.O_m0_rd_data_valid, 1);
    @(negedge clk);
    ifr.I_rd_data_valid = 0;
    #1;
    chk("st_done", ifr.O_busy, 0);

    // Undefined command: issued, then straight back to IDLE
    @(negedge clk);
    ifr.I_m1_cmd_en = 1; ifr.I_m1_cmd = 3'd5; ifr.I_m1_addr = 28'h0000055; ifr.I_m1_burst_number = 6'd2;
    @(negedge clk);
    ifr.I_m1_cmd_en = 0;
    #1;
    chk("odd_cmd", ifr.O_cmd, 5);
    chk("odd_cmd_en", ifr.O_cmd_en, 1);
    @(negedge clk);
    #1;
    chk("odd_no_data", ifr.O_busy, 0);

    // Burst 63 gives exactly 64 beats
    @(negedge clk);
    ifr.I_wr_data_rdy = 1;
    ifr.I_m0_cmd_en = 1; ifr.I_m0_cmd = 3'd0; ifr.I_m0_addr = 28'h0000400; ifr.I_m0_burst_number = 6'd63;
    @(negedge clk);
    ifr.I_m0_cmd_en = 0;
    #1;
    chk("b63_burst", ifr.O_app_burst_number, 63);
    for (int b = 0; b < 64; b++) begin
      @(negedge clk);
      ifr.I_m0_wr_data_en = 1;
      #1;
      chk($sformatf("b63_beat%0d_busy", b), ifr.O_busy, 1);
    end
    @(negedge clk);
    #1;
    chk("b63_done", ifr.O_busy, 0);
    clear_inputs();

    // Reset during beat 3 of an 8-beat M1 write
    @(negedge clk);
    ifr.I_cmd_ready = 1; ifr.I_wr_data_rdy = 1;
    ifr.I_m1_cmd_en = 1; ifr.I_m1_cmd = 3'd0; ifr.I_m1_addr = 28'h0333330; ifr.I_m1_burst_number = 6'd7;
    @(negedge clk);
    ifr.I_m1_cmd_en = 0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      ifr.I_m1_wr_data_en = 1; ifr.I_m1_wr_data = '1;
    end
    @(negedge clk);
    #1;
    chk("rs_pre_wr_en", ifr.O_wr_data_en, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_busy", ifr.O_busy, 0);
    chk("rs_owner", ifr.O_owner, 0);
    chk("rs_wr_en", ifr.O_wr_data_en, 0);
    chk("rs_wr_data", ifr.O_wr_data, 0);
    chk("rs_rdy1", ifr.O_m1_wr_data_rdy, 0);
    chk("rs_addr", ifr.O_addr, 0);
    chk("rs_burst", ifr.O_app_burst_number, 0);
    chk("rs_timeout", ifr.O_rd_timeout, 0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ifr.I_cmd_ready = 1;
    ifr.I_m1_cmd_en = 1; ifr.I_m1_cmd = 3'd1; ifr.I_m1_addr = 28'h0999990; ifr.I_m1_burst_number = 0;
    #1;
    chk("rs_m1_rdy_rr", ifr.O_m1_cmd_ready, 1);
    chk("rs_m1_rdy_pr", ifp.O_m1_cmd_ready, 1);
    @(negedge clk);
    ifr.I_m1_cmd_en = 0;
    #1;
    chk("rs_m1_owner", ifr.O_owner, 1);
    chk("rs_m1_cmd", ifr.O_cmd, 1);
    @(negedge clk);
    ifr.I_rd_data_valid = 1;
    #1;
    chk("rs_m1_v1", ifr.O_m1_rd_data_valid, 1);
    chk("rs_m1_v0", ifr.O_m0_rd_data_valid, 0);
    @(negedge clk);
    ifr.I_rd_data_valid = 0;
    #1;
    chk("rs_m1_done", ifr.O_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
